// File: rtl/ysyx_25040111_axi_mem_slave.sv
// AXI4-subset memory responder: independent read/write FSMs over a 32-bit word array.
// The array has no reset and is reachable hierarchically as <inst>.mem for an external preload hook.
module ysyx_25040111_axi_mem_slave #(
  parameter int          ADDR_W = 12,
  parameter logic [31:0] BASE   = 32'h8000_0000,
  parameter int          RD_LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic [3:0]  rid,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  output logic [3:0]  bid
);
  localparam int          IDX_W       = ADDR_W - 2;
  localparam int          DEPTH       = 1 << IDX_W;
  localparam int          LAT_W       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef struct packed {
    r_state_e rd;
    w_state_e wr;
  } dbg_state_t;

  logic [31:0] mem [DEPTH];

  r_state_e         r_state, r_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_len, r_beat;
  logic             r_fixed, r_hit;
  logic [LAT_W-1:0] lat_cnt;

  w_state_e         w_state, w_state_nxt;
  logic [IDX_W-1:0] w_idx;
  logic [7:0]       w_len, w_beat;
  logic             w_fixed, w_hit, w_err;

  dbg_state_t dbg_state;
  logic       ar_hit, aw_hit;
  logic       ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic       unused_ok;

  // A transfer happens on any rising edge where valid and ready are both high; a
  // valid, once raised, holds its payload until that edge. Ready never depends on valid.
  assign ar_hs = arvalid & arready;
  assign r_hs  = rvalid & rready;
  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign b_hs  = bvalid & bready;

  assign ar_hit    = (araddr[31:ADDR_W] == BASE[31:ADDR_W]);
  assign aw_hit    = (awaddr[31:ADDR_W] == BASE[31:ADDR_W]);
  assign dbg_state = '{rd: r_state, wr: w_state};
  assign unused_ok = ^{arsize, awsize, araddr[1:0], awaddr[1:0], dbg_state};

  // ---------------- read channel ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= R_IDLE;
    else       r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nxt = (RD_LAT > 0) ? R_WAIT : R_DATA;
      R_WAIT:  if (lat_cnt == '0) r_state_nxt = R_DATA;
      R_DATA:  if (r_hs && rlast) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_idx   <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_fixed <= 1'b0;
      r_hit   <= 1'b0;
      rid     <= '0;
      lat_cnt <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (ar_hs) begin
          r_idx   <= araddr[ADDR_W-1:2];
          r_len   <= arlen;
          r_beat  <= '0;
          r_fixed <= (arburst == 2'b00);
          r_hit   <= ar_hit;
          rid     <= arid;
          lat_cnt <= (RD_LAT > 0) ? LAT_W'(RD_LAT - 1) : '0;
        end
        R_WAIT: if (lat_cnt != '0) lat_cnt <= lat_cnt - LAT_W'(1);
        R_DATA: if (r_hs && !rlast) begin
          r_beat <= r_beat + 8'd1;
          // The index is only IDX_W wide, so INCR wraps inside the window.
          if (!r_fixed) r_idx <= r_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign arready = (r_state == R_IDLE) & ~reset;
  assign rvalid  = (r_state == R_DATA);
  assign rlast   = rvalid & (r_beat == r_len);
  assign rresp   = (rvalid & ~r_hit) ? RESP_SLVERR : RESP_OKAY;
  assign rdata   = (rvalid & r_hit) ? mem[r_idx] : 32'h0;

  // ---------------- write channel ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) w_state <= W_IDLE;
    else       w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
      W_DATA:  if (w_hs && wlast) w_state_nxt = W_RESP;
      W_RESP:  if (b_hs) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_idx   <= '0;
      w_len   <= '0;
      w_beat  <= '0;
      w_fixed <= 1'b0;
      w_hit   <= 1'b0;
      w_err   <= 1'b0;
      bid     <= '0;
    end else begin
      case (w_state)
        W_IDLE: if (aw_hs) begin
          w_idx   <= awaddr[ADDR_W-1:2];
          w_len   <= awlen;
          w_beat  <= '0;
          w_fixed <= (awburst == 2'b00);
          w_hit   <= aw_hit;
          w_err   <= 1'b0;
          bid     <= awid;
        end
        W_DATA: if (w_hs) begin
          // wlast must coincide exactly with beat awlen; either disagreement is an error.
          w_err  <= w_err | (wlast != (w_beat == w_len));
          w_beat <= w_beat + 8'd1;
          if (!w_fixed) w_idx <= w_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign awready = (w_state == W_IDLE) & ~reset;
  assign wready  = (w_state == W_DATA);
  assign bvalid  = (w_state == W_RESP);
  assign bresp   = (bvalid & (~w_hit | w_err)) ? RESP_SLVERR : RESP_OKAY;

  always_ff @(posedge clock) begin
    if (w_hs && w_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_ysyx_25040111_axi_mem_slave.sv
// Randomized bench for the AXI memory responder against a word-array reference model.
module tb_ysyx_25040111_axi_mem_slave;
  localparam int          ADDR_W = 12;
  localparam int          DEPTH  = 1 << (ADDR_W - 2);
  localparam int          RD_LAT = 2;
  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam int          TMO    = 200;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [31:0] araddr, rdata;
  logic [3:0]  arid, rid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, rresp;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [31:0] awaddr, wdata;
  logic [3:0]  awid, wstrb, bid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst, bresp;

  int vectors = 0;
  int errors  = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_q [$];
  logic [31:0] wd_q [$];
  logic [3:0]  ws_q [$];

  ysyx_25040111_axi_mem_slave #(.ADDR_W(ADDR_W), .BASE(BASE), .RD_LAT(RD_LAT)) dut (
    .clock(clock), .reset(reset),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model helpers ----------------
  function automatic bit in_window(input logic [31:0] a);
    return (a >> ADDR_W) == (BASE >> ADDR_W);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  task automatic load_words(input int n, input bit full_strb);
    wd_q.delete();
    ws_q.delete();
    for (int i = 0; i < n; i++) begin
      wd_q.push_back($urandom);
      ws_q.push_back(full_strb ? 4'hF : 4'($urandom_range(0, 15)));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_burst(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                             input logic [1:0] burst, input bit w_early, input bit hold_b);
    int n, idx, t;
    bit exp_err;
    logic [31:0] w;
    n       = wd_q.size();
    idx     = word_of(addr);
    exp_err = !in_window(addr) || (n != int'(len) + 1);
    @(negedge clock);
    awvalid = 1'b1; awaddr = addr; awid = id; awlen = len; awburst = burst;
    awsize  = 3'($urandom_range(0, 2));
    if (w_early) begin
      wvalid = 1'b1; wdata = wd_q[0]; wstrb = ws_q[0]; wlast = (n == 1);
    end
    t = 0;
    while (awready !== 1'b1) begin
      @(negedge clock);
      t++;
      if (t > TMO) begin
        vectors++; errors++;
        $display("FAIL aw_timeout: awready=%b expected 1", awready);
        awvalid = 1'b0; wvalid = 1'b0;
        return;
      end
    end
    vectors++;
    if (wready !== 1'b0) begin
      errors++; $display("FAIL wready_during_aw: wready=%b expected 0", wready);
    end
    @(negedge clock);
    awvalid = 1'b0;
    vectors++;
    if (wready !== 1'b1) begin
      errors++; $display("FAIL wready_after_aw: wready=%b expected 1", wready);
    end
    for (int b = 0; b < n; b++) begin
      if (b > 0 && $urandom_range(0, 3) == 0) begin
        wvalid = 1'b0;
        @(negedge clock);
      end
      wvalid = 1'b1; wdata = wd_q[b]; wstrb = ws_q[b]; wlast = (b == n - 1);
      t = 0;
      while (wready !== 1'b1) begin
        @(negedge clock);
        t++;
        if (t > TMO) begin
          vectors++; errors++;
          $display("FAIL w_timeout: wready=%b expected 1", wready);
          wvalid = 1'b0;
          return;
        end
      end
      if (in_window(addr)) begin
        w = ref_mem[idx];
        for (int k = 0; k < 4; k++) if (ws_q[b][k]) w[8*k +: 8] = wd_q[b][8*k +: 8];
        ref_mem[idx] = w;
      end
      if (burst != 2'b00) idx = (idx + 1) % DEPTH;
      @(negedge clock);
    end
    wvalid = 1'b0; wlast = 1'b0;
    vectors++;
    if ({bvalid, bresp, bid} !== {1'b1, exp_err ? 2'b10 : 2'b00, id}) begin
      errors++;
      $display("FAIL b_resp: bvalid/bresp/bid=%b/%b/%h expected 1/%b/%h",
               bvalid, bresp, bid, exp_err ? 2'b10 : 2'b00, id);
    end
    if (hold_b) return;
    repeat ($urandom_range(0, 2)) begin
      @(negedge clock);
      vectors++;
      if (bvalid !== 1'b1) begin
        errors++; $display("FAIL b_hold: bvalid=%b expected 1", bvalid);
      end
    end
    bready = 1'b1;
    @(negedge clock);
    bready = 1'b0;
    vectors++;
    if ({bvalid, awready} !== 2'b01) begin
      errors++; $display("FAIL b_done: bvalid/awready=%b/%b expected 0/1", bvalid, awready);
    end
  endtask

  // mode 0: rready always high, 1: toggles 1/0, 2: random
  task automatic read_burst(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [1:0] burst, input int mode);
    int idx, t, lat, beat;
    bit hit, tog;
    logic [1:0] eresp;
    hit   = in_window(addr);
    idx   = word_of(addr);
    eresp = hit ? 2'b00 : 2'b10;
    exp_q.delete();
    for (int i = 0; i <= int'(len); i++)
      exp_q.push_back(hit ? ref_mem[(idx + ((burst != 2'b00) ? i : 0)) % DEPTH] : 32'h0);
    @(negedge clock);
    arvalid = 1'b1; araddr = addr; arid = id; arlen = len; arburst = burst;
    arsize  = 3'($urandom_range(0, 2));
    t = 0;
    while (arready !== 1'b1) begin
      @(negedge clock);
      t++;
      if (t > TMO) begin
        vectors++; errors++;
        $display("FAIL ar_timeout: arready=%b expected 1", arready);
        arvalid = 1'b0;
        return;
      end
    end
    @(negedge clock);
    arvalid = 1'b0;
    lat = 1;
    while (rvalid !== 1'b1) begin
      vectors++;
      if (arready !== 1'b0) begin
        errors++; $display("FAIL ar_busy: arready=%b expected 0", arready);
      end
      @(negedge clock);
      lat++;
      if (lat > TMO) begin
        vectors++; errors++;
        $display("FAIL r_timeout: rvalid=%b expected 1", rvalid);
        return;
      end
    end
    vectors++;
    if (lat != RD_LAT + 1) begin
      errors++; $display("FAIL r_latency: first rvalid after %0d cycles expected %0d", lat, RD_LAT + 1);
    end
    beat = 0;
    tog  = 1'b1;
    while (beat <= int'(len)) begin
      case (mode)
        0:       rready = 1'b1;
        1:       begin rready = tog; tog = ~tog; end
        default: rready = 1'($urandom_range(0, 1));
      endcase
      vectors++;
      if ({rvalid, rdata, rresp, rlast, rid, arready} !==
          {1'b1, exp_q[0], eresp, (beat == int'(len)), id, 1'b0}) begin
        errors++;
        $display("FAIL r_beat%0d: valid/data/resp/last/id/arready=%b/%h/%b/%b/%h/%b expected 1/%h/%b/%b/%h/0",
                 beat, rvalid, rdata, rresp, rlast, rid, arready, exp_q[0], eresp,
                 (beat == int'(len)), id);
      end
      if (rready) begin
        void'(exp_q.pop_front());
        beat++;
      end
      @(negedge clock);
    end
    rready = 1'b0;
    vectors++;
    if ({rvalid, arready} !== 2'b01) begin
      errors++; $display("FAIL r_done: rvalid/arready=%b/%b expected 0/1", rvalid, arready);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    arvalid = 0; araddr = '0; arid = '0; arlen = '0; arsize = '0; arburst = '0; rready = 0;
    awvalid = 0; awaddr = '0; awid = '0; awlen = '0; awsize = '0; awburst = '0;
    wvalid = 0; wdata = '0; wstrb = '0; wlast = 0; bready = 0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    vectors++;
    if ({arready, awready, rvalid, rlast, wready, bvalid, rresp, bresp, rid, bid} !== 17'h0) begin
      errors++;
      $display("FAIL reset_outputs: ar/aw/rv/rl/wr/bv=%b%b%b%b%b%b rresp/bresp=%b/%b rid/bid=%h/%h expected all 0",
               arready, awready, rvalid, rlast, wready, bvalid, rresp, bresp, rid, bid);
    end
    reset = 1'b0;
    @(negedge clock);
    vectors++;
    if ({arready, awready} !== 2'b11) begin
      errors++; $display("FAIL reset_release: arready/awready=%b/%b expected 1/1", arready, awready);
    end
  endtask

  task automatic test_fill();
    for (int s = 0; s < 4; s++) begin
      load_words(256, 1'b1);
      write_burst(BASE + 32'(s * 1024), 4'($urandom_range(0, 15)), 8'd255, 2'b01,
                  1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  task automatic test_latency();
    wd_q = '{32'hDEAD_BEEF};
    ws_q = '{4'hF};
    write_burst(32'h8000_0008, 4'd1, 8'd0, 2'b01, 1'b0, 1'b0);
    read_burst(32'h8000_0008, 4'd3, 8'd0, 2'b01, 0);
  endtask

  task automatic test_incr_wrap();
    wd_q = '{32'h11, 32'h22, 32'h33, 32'h44};
    ws_q = '{4'hF, 4'hF, 4'hF, 4'hF};
    write_burst(32'h8000_0FF8, 4'd2, 8'd3, 2'b01, 1'b0, 1'b0);
    read_burst(32'h8000_0FF8, 4'd5, 8'd3, 2'b01, 1);
  endtask

  task automatic test_fixed();
    wd_q = '{$urandom, $urandom, $urandom};
    ws_q = '{4'b0001, 4'b0100, 4'b1000};
    write_burst(32'h8000_0010, 4'd6, 8'd2, 2'b00, 1'b0, 1'b0);
    read_burst(32'h8000_0010, 4'd7, 8'd2, 2'b00, 2);
  endtask

  task automatic test_strobe();
    wd_q = '{32'h1234_5678};
    ws_q = '{4'hF};
    write_burst(32'h8000_0020, 4'd8, 8'd0, 2'b01, 1'b0, 1'b0);
    wd_q = '{32'h0000_AB00};
    ws_q = '{4'b0010};
    write_burst(32'h8000_0020, 4'd9, 8'd0, 2'b01, 1'b1, 1'b0);
    read_burst(32'h8000_0020, 4'd10, 8'd0, 2'b01, 0);
  endtask

  task automatic test_miss();
    read_burst(32'h1000_0000, 4'd11, 8'd1, 2'b01, 0);
    wd_q = '{32'hCAFE_F00D};
    ws_q = '{4'hF};
    write_burst(32'h1000_0000, 4'd12, 8'd0, 2'b01, 1'b1, 1'b0);
    read_burst(32'h8000_0000, 4'd13, 8'd0, 2'b01, 0);
    load_words(2, 1'b1);
    write_burst(32'h8000_0040, 4'd14, 8'd0, 2'b01, 1'b0, 1'b0);
    load_words(2, 1'b1);
    write_burst(32'h8000_0050, 4'd15, 8'd3, 2'b01, 1'b0, 1'b0);
    read_burst(32'h8000_0040, 4'd4, 8'd7, 2'b01, 2);
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [7:0]  len;
    logic [1:0]  bt;
    for (int n = 0; n < 24; n++) begin
      a   = ($urandom_range(0, 7) == 0) ? 32'h4000_0000 + $urandom_range(0, 4095)
                                        : BASE + $urandom_range(0, 4095);
      len = 8'($urandom_range(0, 15));
      bt  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        load_words(int'(len) + 1, 1'b0);
        write_burst(a, 4'($urandom_range(0, 15)), len, bt, 1'($urandom_range(0, 1)), 1'b0);
      end else begin
        read_burst(a, 4'($urandom_range(0, 15)), len, bt, int'($urandom_range(0, 2)));
      end
    end
  endtask

  task automatic test_concurrent();
    load_words(6, 1'b0);
    fork
      read_burst(BASE + 32'h100, 4'd1, 8'd7, 2'b01, 2);
      write_burst(BASE + 32'h800, 4'd2, 8'd5, 2'b01, 1'b1, 1'b0);
    join
    read_burst(BASE + 32'h800, 4'd3, 8'd5, 2'b01, 0);
  endtask

  task automatic test_reset_mid();
    int t;
    wd_q = '{32'h5A5A_1234};
    ws_q = '{4'hF};
    write_burst(BASE + 32'h300, 4'd6, 8'd0, 2'b01, 1'b0, 1'b1);
    @(negedge clock);
    arvalid = 1'b1; araddr = BASE + 32'h400; arid = 4'd9; arlen = 8'd3; arburst = 2'b01;
    t = 0;
    while (arready !== 1'b1 && t < TMO) begin @(negedge clock); t++; end
    @(negedge clock);
    arvalid = 1'b0;
    t = 0;
    while (rvalid !== 1'b1 && t < TMO) begin @(negedge clock); t++; end
    rready = 1'b1;
    @(negedge clock);
    rready = 1'b0;
    vectors++;
    if ({rvalid, rlast, bvalid} !== 3'b101) begin
      errors++; $display("FAIL mid_burst: rvalid/rlast/bvalid=%b/%b/%b expected 1/0/1", rvalid, rlast, bvalid);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({rvalid, bvalid, arready, awready, wready, rlast} !== 6'b0) begin
      errors++;
      $display("FAIL reset_async: rv/bv/ar/aw/wr/rl=%b%b%b%b%b%b expected 000000",
               rvalid, bvalid, arready, awready, wready, rlast);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    vectors++;
    if ({arready, awready, rvalid, bvalid} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_mid_release: ar/aw/rv/bv=%b%b%b%b expected 1100", arready, awready, rvalid, bvalid);
    end
    read_burst(BASE + 32'h300, 4'd7, 8'd0, 2'b01, 0);
    read_burst(BASE + 32'h400, 4'd8, 8'd3, 2'b01, 0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_fill();
    test_latency();
    test_incr_wrap();
    test_fixed();
    test_strobe();
    test_miss();
    test_random();
    test_concurrent();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
